shift_add_mul_sched: RTL and testbench
======================================

Name: shift_add_mul_sched

Overview:
- Two-requester scheduler that time-shares one multi-cycle shift-and-add multiplier datapath (one multiplier bit per clock).
- Arbitrates requests round-robin, captures operands, and sequences the accumulate/shift iterations.
- Returns the product, tagged with the requester ID, on a single valid/ready response channel.
- Sits between requesting blocks and the arithmetic unit; owns the datapath registers itself.

Parameters:
- m, 8, width of operand A (multiplicand)
- n, 8, width of operand B (multiplier); also the iteration count

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a  input  m  requester 0 multiplicand
- req0_b  input  n  requester 0 multiplier
- req1_valid  input  1  requester 1 has operands
- req1_ready  output  1  requester 1 operands accepted this cycle
- req1_a  input  m  requester 1 multiplicand
- req1_b  input  n  requester 1 multiplier
- resp_valid  output  1  product available
- resp_ready  input  1  consumer takes product
- resp_id  output  1  requester that owns the product
- resp_data  output  m+n  unsigned product A*B
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE; resp_valid=0, resp_id=0, resp_data=0, busy=0.
  - Round-robin pointer last_grant=1, so requester 0 wins first. Iteration count=0.
  - Reset mid-operation: the in-flight operation is discarded with no response; no ready is asserted in the reset cycle.
- Arbitration (IDLE only):
  - Only one requester valid -> grant it.
  - Both valid -> grant the requester not equal to last_grant.
  - reqX_ready = (state==IDLE) & grant==X. It is combinational and asserted in the same cycle as valid.
  - Handshake completes when valid & ready are both high at the edge.
  - The ready of the requester not granted stays 0; its request must be held until accepted.
- Capture (at the accept edge):
  - acc=0; a_sh = zero-extended A (m+n bits); b_sh=B; id=granted requester; last_grant=granted; count=0.
  - state -> RUN.
- RUN (one iteration per cycle):
  - if b_sh[0]=1, acc = acc + a_sh (mod 2^(m+n); cannot overflow for unsigned operands).
  - a_sh <<= 1; b_sh >>= 1; count++.
  - After the iteration with count==n-1 -> DONE.
  - The bound is exactly n iterations; no extra (n+1)th iteration. Zero bits add nothing.
- DONE:
  - resp_valid=1, resp_data=acc, resp_id=id. Outputs are held stable while resp_ready=0.
  - On resp_valid & resp_ready -> IDLE and resp_valid=0 next cycle.
  - A new request can be accepted in the cycle after the response handshake, not the same cycle.
- Latency: accept at edge T; resp_valid high from the cycle after edge T+n. That is n+1 cycles from accept to first resp_valid.
- Throughput: at most one operation per n+2 cycles with resp_ready tied high.
- Requests arriving while busy are ignored until IDLE; ready stays 0.
- resp_data is 0 outside DONE.

Optional Feature:
- Macro: SHIFT_ADD_EARLY_TERM_EN
- Defined:
  - In RUN, go to DONE after any iteration where the shifted b_sh becomes 0, or count==n-1, whichever comes first.
  - Latency to resp_valid = (index of B's highest set bit)+2 cycles; B=0 gives 2 cycles.
  - Product value is identical to the non-early-termination result.
- Undefined: fixed n iterations as above; latency is independent of the data.

Test Plan:
- Single request: req0 A=13, B=11 -> req0_ready pulses 1 cycle; resp_valid after 9 cycles (n=8); resp_data=143, resp_id=0.
- Corner values: A=255, B=255 -> 65025. A=0, B=200 -> 0. A=77, B=0 -> 0. A=1, B=128 -> 128 (checks the MSB iteration is included).
- Simultaneous requests: after reset, req0 (A=3, B=5) and req1 (A=7, B=9) both valid -> req0 served first (15, id=0), then req1 (63, id=1). Repeat both valid -> alternate 0,1,0,1.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid, resp_data and resp_id stable; req1_valid=1 during this period gets no ready; after release, req1 is accepted next cycle.
- Reset mid-RUN: assert rst at iteration 4 of A=200, B=100 -> no response; all outputs 0; next request 6x7 returns 42 with correct latency.
- With SHIFT_ADD_EARLY_TERM_EN: B=1, A=99 -> resp_valid 2 cycles after accept, data 99. B=128 -> 9 cycles. Random 1000 pairs match A*B with both macro settings.

Source files
------------

// File: rtl/shift_add_mul_sched.sv
// Two-requester round-robin scheduler around a serial shift-and-add multiplier.
// Optional macro SHIFT_ADD_EARLY_TERM_EN stops iterating once the remaining multiplier bits are zero.
module shift_add_mul_sched #(
  parameter int m = 8,
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [m-1:0]     req0_a,
  input  logic [n-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [m-1:0]     req1_a,
  input  logic [n-1:0]     req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [m+n-1:0]   resp_data,
  output logic             busy
);

  localparam int w  = m + n;
  localparam int cw = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [w-1:0]    acc_q, acc_d;
  logic [w-1:0]    a_sh_q, a_sh_d;
  logic [n-1:0]    b_sh_q, b_sh_d;
  logic [cw-1:0]   count_q, count_d;
  logic            id_q, id_d;
  logic            last_grant_q, last_grant_d;

  logic            grant_s;
  logic            accept_s;
  logic [n-1:0]    b_next_s;
  logic            last_iter_s;

  // Arbitration, capture and iteration sequencing.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    count_d      = count_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;

    // Contention goes to whoever was not served last.
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    accept_s = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
    b_next_s = b_sh_q >> 1;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    last_iter_s = (count_q == cw'(n - 1)) || (b_next_s == '0);
`else
    last_iter_s = (count_q == cw'(n - 1));
`endif

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          acc_d        = '0;
          a_sh_d       = grant_s ? w'(req1_a) : w'(req0_a);
          b_sh_d       = grant_s ? req1_b : req0_b;
          id_d         = grant_s;
          last_grant_d = grant_s;
          count_d      = '0;
          state_d      = RUN;
        end else begin
          state_d      = IDLE;
        end
      end
      RUN: begin
        if (b_sh_q[0]) begin
          acc_d = acc_q + a_sh_q;
        end else begin
          acc_d = acc_q;
        end
        a_sh_d  = a_sh_q << 1;
        b_sh_d  = b_next_s;
        count_d = count_q + cw'(1);
        if (last_iter_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      count_q      <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      count_q      <= count_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_ready = accept_s & ~grant_s;
  assign req1_ready = accept_s & grant_s;
  assign resp_valid = (state_q == DONE);
  assign resp_data  = resp_valid ? acc_q : '0;
  assign resp_id    = resp_valid ? id_q : 1'b0;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_add_mul_sched.sv
// Directed self-checking bench for shift_add_mul_sched (m=n=8).
module tb_shift_add_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_add_mul_sched #(.m(8), .n(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges from the accept edge (inclusive) until resp_valid is first seen.
  function automatic int exp_lat(input logic [7:0] b);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    int h = 0;
    for (int i = 0; i < 8; i++) if (b[i]) h = i;
    return h + 2;
`else
    return 9;
`endif
  endfunction

  // Called #1 after the accept edge; waits for the response, optionally stalls it, then completes it.
  task automatic wait_resp(input string tag, input logic [15:0] exp_data, input logic exp_id,
                           input int lat_exp, input int hold);
    int lat = 1;
    resp_ready = (hold == 0);
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, 32'(resp_data), 32'(exp_data));
    chk({tag, "_id"}, 32'(resp_id), 32'(exp_id));
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(resp_data), 32'(exp_data));
      chk({tag, "_hold_id"}, 32'(resp_id), 32'(exp_id));
      chk({tag, "_hold_rdy1"}, 32'(req1_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_after_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_after_data"}, 32'(resp_data), 32'd0);
  endtask

  // Single request from one requester, response taken immediately.
  task automatic single(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b);
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    chk({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_ready_drop"}, 32'(id ? req1_ready : req0_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_resp(tag, 16'(a) * 16'(b), id, exp_lat(b), 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
    @(posedge clk); #1;
    // A valid request during reset must not see ready.
    req0_valid = 1'b1; #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);

    // After reset, simultaneous requests alternate starting with requester 0.
    req0_a = 8'd3; req0_b = 8'd5; req1_a = 8'd7; req1_b = 8'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (i % 2 == 0) wait_resp("rr0", 16'd15, 1'b0, exp_lat(8'd5), 0);
      else            wait_resp("rr1", 16'd63, 1'b1, exp_lat(8'd9), 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    single("s13x11", 1'b0, 8'd13, 8'd11);
    single("s255x255", 1'b0, 8'd255, 8'd255);
    single("s0x200", 1'b1, 8'd0, 8'd200);
    single("s77x0", 1'b0, 8'd77, 8'd0);
    single("s1x128", 1'b1, 8'd1, 8'd128);
    single("s99x1", 1'b0, 8'd99, 8'd1);

    // Backpressure: response stalls 5 cycles while requester 1 waits.
    req0_a = 8'd10; req0_b = 8'd20; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_a = 8'd9; req1_b = 8'd9; req1_valid = 1'b1;
    wait_resp("bp", 16'd200, 1'b0, exp_lat(8'd20), 5);
    chk("bp_req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("bp_req1_busy", 32'(busy), 32'd1);
    wait_resp("bp_r1", 16'd81, 1'b1, exp_lat(8'd9), 0);

    // Reset in the middle of RUN discards the operation.
    req0_a = 8'd200; req0_b = 8'd100; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(resp_valid), 32'd0);
    chk("mid_data", 32'(resp_data), 32'd0);
    chk("mid_id", 32'(resp_id), 32'd0);
    begin
      int seen = 0;
      repeat (12) begin @(posedge clk); #1; if (resp_valid || busy) seen++; end
      chk("mid_no_resp", 32'(seen), 32'd0);
    end
    single("s6x7", 1'b0, 8'd6, 8'd7);

    // A batch of random operand pairs on alternating requesters.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      single("rand", 1'(i % 2), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
